// File: rtl/sample_packer.sv
// Packs a stream of samples into a fixed-width lane vector for a downstream adder tree.
// Unfilled lanes stay zero, and a vector may be closed early with s_last.
module sample_packer #(
   parameter int unsigned INPUTS_NUM  = 8,
   parameter int unsigned IDATA_WIDTH = 8,
   localparam int unsigned CNT_W      = $clog2(INPUTS_NUM + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [IDATA_WIDTH-1:0]                s_data,
   input  logic                                  s_last,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] odata,
   output logic [CNT_W-1:0]                      m_count
);

   typedef enum logic [0:0] {StFill, StFull} state_e;

   state_e                                 state_q, state_d;
   logic [CNT_W-1:0]                       idx_q, idx_d;
   logic [CNT_W-1:0]                       count_q, count_d;
   logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] lanes_q, lanes_d;
   logic                                   s_in_hs, m_hs, idx_at_end;

   // In FULL the upstream may only push a sample as the pending vector leaves.
   assign s_ready    = (state_q == StFill) ? 1'b1 : m_ready;
   assign m_valid    = (state_q == StFull);
   assign s_in_hs    = s_valid && s_ready;
   assign m_hs       = m_valid && m_ready;
   assign idx_at_end = (idx_q == CNT_W'(INPUTS_NUM - 1));
   assign odata      = lanes_q;
   assign m_count    = count_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      lanes_d = lanes_q;
      unique case (state_q)
         StFill: begin
            if (s_in_hs) begin
               for (int unsigned i = 0; i < INPUTS_NUM; i++) begin
                  if (idx_q == CNT_W'(i)) begin
                     lanes_d[i] = s_data;
                  end
               end
               if (idx_at_end || s_last) begin
                  state_d = StFull;
                  count_d = idx_q + CNT_W'(1);
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + CNT_W'(1);
               end
            end
         end
         StFull: begin
            if (m_hs) begin
               lanes_d = '0;
               count_d = '0;
               idx_d   = '0;
               state_d = StFill;
               if (s_in_hs) begin
                  // Overlapped sample opens the next vector in lane 0.
                  lanes_d[0] = s_data;
                  if (s_last) begin
                     state_d = StFull;
                     count_d = CNT_W'(1);
                  end else begin
                     idx_d = CNT_W'(1);
                  end
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFill;
         idx_q   <= '0;
         count_q <= '0;
         lanes_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer: a queue-based reference model builds expected vectors
// from accepted samples; a monitor pops and compares on each output handshake.
module tb_sample_packer;

   localparam int unsigned N    = 8;
   localparam int unsigned W    = 8;
   localparam int unsigned CNTW = $clog2(N + 1);

   typedef struct {
      logic [N*W-1:0] data;
      int             cnt;
   } vec_t;

   logic                clk;
   logic                rst_n;
   logic                s_valid;
   logic                s_ready;
   logic [W-1:0]        s_data;
   logic                s_last;
   logic                m_valid;
   logic                m_ready;
   logic [N-1:0][W-1:0] odata;
   logic [CNTW-1:0]     m_count;

   int checks = 0;
   int errors = 0;
   int sent_total = 0;
   int rcv_total = 0;

   logic [W-1:0] cur[$];
   vec_t         exp_q[$];

   sample_packer #(
      .INPUTS_NUM (N),
      .IDATA_WIDTH(W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data (s_data),
      .s_last (s_last),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .odata  (odata),
      .m_count(m_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: group accepted samples into vectors of N, or fewer when s_last closes.
   always @(negedge clk) begin
      if (rst_n && s_valid && s_ready) begin
         vec_t v;
         cur.push_back(s_data);
         sent_total++;
         if (cur.size() == N || s_last) begin
            v.data = '0;
            foreach (cur[i]) v.data[i*W +: W] = cur[i];
            v.cnt = cur.size();
            exp_q.push_back(v);
            cur.delete();
         end
      end
   end

   // Monitor: every output handshake must match the oldest expected vector.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         vec_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vector: got data=%h count=%0d, expected no vector", odata,
                     m_count);
         end else begin
            e = exp_q.pop_front();
            if (odata !== e.data || m_count !== CNTW'(e.cnt)) begin
               errors++;
               $display("FAIL vector: got data=%h count=%0d, expected data=%h count=%0d", odata,
                        m_count, e.data, e.cnt);
            end
            rcv_total += int'(m_count);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present a sample and hold it until accepted; returns 1ns after the accepting edge.
   task automatic send(input logic [W-1:0] d, input logic l);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got s_ready=0 for 200 cycles, expected acceptance");
      end
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic settle();
      idle();
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cur.delete();
      exp_q.delete();
   endtask

   logic [N*W-1:0] snap;
   logic [CNTW-1:0] snap_cnt;
   int             sum;
   int             n_acc;
   int             base_sent;
   int             base_rcv;
   bit             acc;

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      #1;
      chk("reset_s_ready", 64'(s_ready), 64'd1);
      chk("reset_m_valid", 64'(m_valid), 64'd0);
      chk("reset_odata", 64'(odata), 64'd0);
      #11 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full vector 1..8 back to back.
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         send(W'(i), 1'b0);
         if (i == 7) chk("full_no_early_valid", 64'(m_valid), 64'd0);
      end
      idle();
      chk("full_m_valid", 64'(m_valid), 64'd1);
      chk("full_m_count", 64'(m_count), 64'd8);
      sum = 0;
      for (int i = 0; i < N; i++) sum += int'(odata[i]);
      chk("full_sum", 64'(sum), 64'd36);
      settle();

      // Early close after 3 samples.
      send(8'd10, 1'b0);
      send(8'd20, 1'b0);
      send(8'd30, 1'b1);
      idle();
      chk("early_m_count", 64'(m_count), 64'd3);
      chk("early_odata", 64'(odata), 64'h0000_0000_001E_140A);
      settle();

      // Backpressure then overlapped sample.
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(W'(8'hA0 + i), (i == 4));
      snap     = odata;
      snap_cnt = m_count;
      s_valid  = 1'b1;
      s_data   = 8'h55;
      s_last   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_s_ready", 64'(s_ready), 64'd0);
         chk("bp_odata_stable", 64'(odata), 64'(snap));
         chk("bp_count_stable", 64'(m_count), 64'(snap_cnt));
         @(posedge clk);
         #1;
      end
      m_ready = 1'b1;
      send(8'h55, 1'b0);
      idle();
      chk("overlap_m_valid", 64'(m_valid), 64'd0);
      chk("overlap_odata", 64'(odata), 64'h55);
      for (int i = 1; i < 8; i++) send(W'(8'hC0 + i), 1'b0);
      settle();

      // Overlapped sample that also closes: single-lane vector stays in FULL.
      m_ready = 1'b0;
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      send(8'd3, 1'b1);
      m_ready = 1'b1;
      send(8'h77, 1'b1);
      idle();
      chk("single_m_valid", 64'(m_valid), 64'd1);
      chk("single_m_count", 64'(m_count), 64'd1);
      chk("single_odata", 64'(odata), 64'h77);
      settle();

      // Reset while a vector is pending under backpressure.
      m_ready = 1'b0;
      send(8'h12, 1'b0);
      send(8'h34, 1'b1);
      idle();
      #2;
      do_reset();
      #1;
      chk("rst_full_odata", 64'(odata), 64'd0);
      chk("rst_full_m_valid", 64'(m_valid), 64'd0);
      chk("rst_full_m_count", 64'(m_count), 64'd0);
      chk("rst_full_s_ready", 64'(s_ready), 64'd1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-fill, then a fresh vector with no stale lanes.
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(W'(8'h11 * (i + 1)), 1'b0);
      idle();
      #2;
      do_reset();
      #1;
      chk("rst_fill_odata", 64'(odata), 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'hFF, 1'b0);
      send(8'h80, 1'b0);
      for (int i = 1; i <= 6; i++) send(W'(i), 1'b0);
      idle();
      chk("rst_fill_count", 64'(m_count), 64'd8);
      chk("rst_fill_vector", 64'(odata), 64'h0605_0403_0201_80FF);
      settle();

      // Random valid/ready/last stress.
      base_sent = sent_total;
      base_rcv  = rcv_total;
      n_acc     = 0;
      for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
         @(negedge clk);
         acc = s_valid && s_ready;
         if (acc) n_acc++;
         @(posedge clk);
         #1;
         if (acc || !s_valid) begin
            s_valid = ($urandom_range(0, 99) < 60);
            s_data  = W'($urandom);
            s_last  = ($urandom_range(0, 9) == 0);
         end
         m_ready = ($urandom_range(0, 99) < 60);
      end
      chk("rand_accepted", 64'(n_acc), 64'd1000);
      idle();
      m_ready = 1'b1;
      send(8'hAB, 1'b1);
      settle();
      chk("rand_exp_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_no_partial", 64'(cur.size()), 64'd0);
      chk("rand_sample_count", 64'(rcv_total - base_rcv), 64'(sent_total - base_sent));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 SHALL have parameter INPUTS_NUM, default 8: lanes per output vector; legal range 2 or more.
REQ-002 SHALL have parameter IDATA_WIDTH, default 8: bits per sample and per lane.
REQ-003 SHALL derive local CNT_W = $clog2(INPUTS_NUM+1).
REQ-004 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port s_valid  input  1: input sample valid.
REQ-007 SHALL have port s_ready  output  1: block can accept a sample.
REQ-008 SHALL have port s_data  input  IDATA_WIDTH: input sample, raw bits, no sign interpretation.
REQ-009 SHALL have port s_last  input  1: accepted sample closes the current vector early.
REQ-010 SHALL have port m_valid  output  1: packed vector available.
REQ-011 SHALL have port m_ready  input  1: downstream accepts the vector.
REQ-012 SHALL have port odata  output  [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] packed: vector sized for a downstream adder tree.
REQ-013 SHALL have port m_count  output  CNT_W: number of filled lanes in odata, 1..INPUTS_NUM while m_valid.

Function
REQ-014 SHALL implement states FILL and FULL, plus a lane index idx of width CNT_W.
REQ-015 SHALL define s_in_hs = s_valid && s_ready and m_hs = m_valid && m_ready.
REQ-016 SHALL, in FILL, drive s_ready=1 and m_valid=0.
REQ-017 SHALL, in FILL, on s_in_hs, write s_data into lane idx, with lane 0 taking the first sample of a vector.
REQ-018 SHALL, in FILL, on s_in_hs, move to FULL when idx==INPUTS_NUM-1 or s_last=1, latch m_count=idx+1, and reset idx to 0; otherwise it SHALL increment idx.
REQ-019 SHALL assert m_valid in the cycle after the closing sample is accepted (latency 1).
REQ-020 SHALL hold lanes not written in the current vector at 0, so a downstream sum equals the sum of the accepted samples.
REQ-021 SHALL, in FULL, drive m_valid=1 and s_ready=m_ready; this combinational ready-to-ready path is intended.
REQ-022 SHALL hold odata and m_count stable while m_valid=1 and m_ready=0.
REQ-023 SHALL, in FULL, on m_hs without s_in_hs, clear all lanes, set m_count=0, and return to FILL with idx=0.
REQ-024 SHALL, in FULL, on m_hs with a simultaneous s_in_hs, start a new vector: lane 0 takes s_data, other lanes take 0, idx=1, state FILL.
REQ-025 SHALL, in the REQ-024 case with s_last=1 on that sample, instead stay in FULL with m_count=1 and lane 0 = s_data.
REQ-026 SHALL accept s_last=1 on the first sample of a vector and produce m_count=1.
REQ-027 SHALL ignore s_last when s_in_hs=0.
REQ-028 SHALL ignore s_data when s_in_hs=0.
REQ-029 SHALL drop no samples and duplicate no samples under any valid/ready pattern.

Reset
REQ-030 SHALL, while rst_n=0, force state=FILL, idx=0, odata=0, m_count=0 and m_valid=0, independent of clk.
REQ-031 SHALL drive s_ready=1 while rst_n=0, matching state FILL.
REQ-032 SHALL discard any partial or pending vector when reset asserts mid-operation.
REQ-033 SHALL place the first sample accepted after reset release in lane 0.

Verification (INPUTS_NUM=8, IDATA_WIDTH=8)
REQ-034 SHALL cover reset: assert rst_n=0 mid-cycle -> odata=0, m_valid=0, m_count=0, s_ready=1 immediately, without waiting for a clock edge.
REQ-035 SHALL cover a full vector: samples 1..8 back-to-back with m_ready=1 -> m_valid=1 one cycle after the 8th; lanes 0..7 = 1..8; m_count=8; sum of lanes = 36.
REQ-036 SHALL cover early close: samples 10,20,30 with s_last on 30 -> lanes 0..2 = 10,20,30; lanes 3..7 = 0; m_count=3.
REQ-037 SHALL cover backpressure and overlap: m_ready=0 for 5 cycles in FULL -> s_ready=0 and odata unchanged; then m_ready=1 with s_valid=1, s_data=0x55 -> next cycle m_valid=0, lane0=0x55, lanes 1..7 = 0, idx=1.
REQ-038 SHALL cover reset mid-fill: 4 samples accepted, then reset pulse, then samples 0xFF,0x80,1..6 -> vector lanes 0..7 = 0xFF,0x80,1,2,3,4,5,6, m_count=8, with no stale data.
REQ-039 SHALL cover random valid/ready stress: 1000 samples with random s_valid, m_ready and s_last (10%) -> concatenation of received lanes 0..m_count-1 equals the sent sequence.
